id_inst_queue: RTL and testbench
================================

// Module: id_inst_queue
// PURPOSE
//  Parametrised instruction queue between IF and ID. Replaces the single-register IF/ID latch and its stall-hold patch.
//  Buffers up to DEPTH {pc, inst} pairs with valid/ready handshakes on both sides.
//  Holds the queue head stable while ID stalls, so instructions are never refetched.
//  On a taken branch/jump it keeps exactly one delay-slot instruction and discards all wrong-path entries.
// PARAMETERS
//  DEPTH   4   number of entries; power of two, >=2
//  PC_W    32  pc width
//  INST_W  32  instruction width
// PORTS
//  clk        in   1               clock, all state on rising edge
//  resetn     in   1               asynchronous, active-low reset
//  in_valid   in   1               IF presents a fetched instruction
//  in_pc      in   PC_W            pc of incoming instruction
//  in_inst    in   INST_W          incoming instruction (inst_sram_rdata)
//  in_ready   out  1               queue accepts a beat this cycle
//  out_valid  out  1               head entry valid for ID
//  out_pc     out  PC_W            head pc
//  out_inst   out  INST_W          head instruction
//  out_ready  in   1               ID consumes head (ID not stalled)
//  br_flush   in   1               head is a taken branch/jump being consumed (qualified with out_valid&out_ready)
//  count      out  $clog2(DEPTH)+1 current occupancy
//  ds_wait    out  1               waiting for the delay slot to arrive
// BEHAVIOUR
//  - Reset (resetn=0, async): rd/wr pointers=0, count=0, ds_wait=0; out_valid=0; in_ready=1 one cycle after release. out_pc/out_inst=0.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (count < DEPTH). A full queue never takes a same-cycle push, even when popping.
//  - Pointers are log2(DEPTH) bits and wrap naturally. count changes by +push-pop.
//  - Latency without bypass: a pushed beat is visible at out_* the next cycle. FIFO order is preserved.
//  - out_* is driven from the head entry. It stays stable while out_valid & ~out_ready.
//  - Flush (br_flush & pop): after the branch pops, exactly one entry survives as the delay slot:
//    * >=1 entry remains behind the head: keep the oldest, drop the rest; the same-cycle push is dropped; count=1.
//    * queue empties and push in the same cycle: that beat is kept as the delay slot; count=1.
//    * queue empties and no push: ds_wait<=1, count=0.
//  - ds_wait=1: in_ready=1. The next push is stored and clears ds_wait. A pop is impossible (queue empty).
//  - br_flush without pop is ignored. A br_flush arriving while ds_wait=1 cannot occur (queue empty).
//  - A mid-operation reset clears every entry and ds_wait immediately. There is no partial state.
// CONFIGURATION
//  ID_QUEUE_BYPASS_EN defined:
//    queue empty & in_valid & out_ready & ~ds_wait -> the beat passes combinationally to out_* in the same cycle.
//    The beat is not written and count is unchanged.
//    With br_flush in a bypass cycle, the queue is empty, so ds_wait<=1.
//    out_valid = (count!=0) | (in_valid & count==0 & ~ds_wait).
//  ID_QUEUE_BYPASS_EN undefined:
//    No combinational in->out path; minimum latency is 1 cycle.
// TESTING
//  1. Reset held 3 cycles, then released -> out_valid=0, count=0, in_ready=1, ds_wait=0.
//  2. Push pc 0x00,0x04,0x08,0x0C with out_ready=0 -> count=4, in_ready=0.
//     Then out_ready=1 -> pops 0x00..0x0C in order; in_ready=1 the cycle after the first pop.
//  3. Queue holds pc 0x10,0x14,0x18; pop 0x10 with br_flush=1 and in_valid pc 0x1C -> next cycle count=1, head pc 0x14.
//     0x18 and 0x1C are gone.
//  4. Queue holds only pc 0x20; pop with br_flush=1, in_valid=0 -> ds_wait=1.
//     Push pc 0x24 -> ds_wait=0, head 0x24. A following push of target 0x80 is queued normally.
//  5. Full queue, out_ready=1 and in_valid=1 in the same cycle -> pop occurs, push refused, count=3.
//     resetn pulsed low mid-stream -> count=0 and out_valid=0 without a clock edge.
//  6. (BYPASS_EN) Empty queue, in_valid pc 0x40, out_ready=1 -> out_valid=1, out_pc=0x40 in the same cycle, count stays 0.
//     (no BYPASS_EN) out_valid first rises the next cycle.

Source files
------------

// File: rtl/id_inst_queue.sv
// Instruction queue between IF and ID: DEPTH-entry FIFO of {pc, inst} that keeps one delay slot on a taken branch.
// Optional same-cycle empty-queue bypass is enabled by defining ID_QUEUE_BYPASS_EN.
module id_inst_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INST_W-1:0]        in_inst,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [PC_W-1:0]          out_pc,
    output logic [INST_W-1:0]        out_inst,
    input  logic                     out_ready,
    input  logic                     br_flush,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ds_wait
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_next;
    logic              push;
    logic              pop;
    logic              flush;
    logic              bypass;
    logic              bypass_vis;
    logic              empty;

    // Handshake and head selection; the bypass path only exists in the bypass build.
    always_comb begin
        empty    = (count == '0);
        rd_next  = rd_ptr + PTR_W'(1);
        in_ready = (count < CNT_W'(DEPTH));
        push     = in_valid & in_ready;
`ifdef ID_QUEUE_BYPASS_EN
        bypass_vis = empty & in_valid & ~ds_wait;
        bypass     = bypass_vis & out_ready;
        out_valid  = ~empty | bypass_vis;
        out_pc     = bypass_vis ? in_pc   : pc_mem[rd_ptr];
        out_inst   = bypass_vis ? in_inst : inst_mem[rd_ptr];
`else
        bypass_vis = 1'b0;
        bypass     = 1'b0;
        out_valid  = ~empty;
        out_pc     = pc_mem[rd_ptr];
        out_inst   = inst_mem[rd_ptr];
`endif
        pop   = out_valid & out_ready;
        flush = pop & br_flush;
    end

    // Storage, pointers and occupancy. A flushing pop collapses the queue to at most one
    // surviving delay-slot entry, or arms ds_wait when there is nothing left to keep.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ds_wait <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (bypass) begin
            if (br_flush) begin
                ds_wait <= 1'b1;
            end
        end else if (flush) begin
            if (count > CNT_W'(1)) begin
                rd_ptr <= rd_next;
                wr_ptr <= rd_next + PTR_W'(1);
                count  <= CNT_W'(1);
            end else if (push) begin
                pc_mem[wr_ptr]   <= in_pc;
                inst_mem[wr_ptr] <= in_inst;
                rd_ptr           <= rd_next;
                wr_ptr           <= wr_ptr + PTR_W'(1);
                count            <= CNT_W'(1);
            end else begin
                rd_ptr  <= rd_next;
                count   <= '0;
                ds_wait <= 1'b1;
            end
        end else begin
            if (push) begin
                pc_mem[wr_ptr]   <= in_pc;
                inst_mem[wr_ptr] <= in_inst;
                wr_ptr           <= wr_ptr + PTR_W'(1);
                ds_wait          <= 1'b0;
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_id_inst_queue.sv
// Self-checking bench for id_inst_queue: queue-based reference model compared every cycle plus directed literal checks.
// Honours ID_QUEUE_BYPASS_EN the same way the design does.
module tb_id_inst_queue;

    localparam int DEPTH = 4;
`ifdef ID_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;
    logic        br_flush;
    logic [2:0]  count;
    logic        ds_wait;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_pc   [$];
    logic [31:0] m_inst [$];
    bit          m_ds;

    id_inst_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
        .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready),
        .br_flush(br_flush), .count(count), .ds_wait(ds_wait)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hA5A5_0000;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic v, input logic [31:0] pc, input logic ordy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst_of(pc);
        out_ready = ordy;
        br_flush  = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: expected visibility and transfer rules computed from the queue contents.
    function automatic bit m_valid();
        return (m_pc.size() != 0) || (BYP && in_valid && !m_ds);
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_pc.delete();
            m_inst.delete();
            m_ds = 1'b0;
        end else begin
            bit push, pop, byp;
            push = in_valid && (m_pc.size() < DEPTH);
            pop  = m_valid() && out_ready;
            byp  = BYP && (m_pc.size() == 0) && in_valid && out_ready && !m_ds;
            if (byp) begin
                if (br_flush) m_ds = 1'b1;
            end else if (pop && br_flush) begin
                void'(m_pc.pop_front());
                void'(m_inst.pop_front());
                if (m_pc.size() >= 1) begin
                    m_pc   = '{m_pc[0]};
                    m_inst = '{m_inst[0]};
                end else if (push) begin
                    m_pc.push_back(in_pc);
                    m_inst.push_back(in_inst);
                end else begin
                    m_ds = 1'b1;
                end
            end else begin
                if (pop) begin
                    void'(m_pc.pop_front());
                    void'(m_inst.pop_front());
                end
                if (push) begin
                    m_pc.push_back(in_pc);
                    m_inst.push_back(in_inst);
                    m_ds = 1'b0;
                end
            end
        end
    end

    // Mid-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (resetn) begin
            bit ev;
            ev = m_valid();
            check_output("cyc_out_valid", 32'(out_valid), 32'(ev));
            check_output("cyc_count", 32'(count), 32'(m_pc.size()));
            check_output("cyc_in_ready", 32'(in_ready), 32'(m_pc.size() < DEPTH));
            check_output("cyc_ds_wait", 32'(ds_wait), 32'(m_ds));
            if (ev) begin
                check_output("cyc_out_pc", out_pc, (m_pc.size() != 0) ? m_pc[0] : in_pc);
                check_output("cyc_out_inst", out_inst, (m_inst.size() != 0) ? m_inst[0] : in_inst);
            end
        end
    end

    initial begin
        resetn = 1'b0;
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);

        // Reset held three cycles
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        check_output("rst_out_valid", 32'(out_valid), 32'd0);
        check_output("rst_count", 32'(count), 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'd1);
        check_output("rst_ds_wait", 32'(ds_wait), 32'd0);
        check_output("rst_out_pc", out_pc, 32'd0);

        // Fill then drain in order
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 32'(i * 4), 1'b0, 1'b0);
            tick();
        end
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check_output("full_count", 32'(count), 32'd4);
        check_output("full_in_ready", 32'(in_ready), 32'd0);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_output("drain_pc", out_pc, 32'(i * 4));
            tick();
            if (i == 0) check_output("drain_in_ready", 32'(in_ready), 32'd1);
        end
        check_output("drain_count", 32'(count), 32'd0);

        // Flush with entries behind the head
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 32'h10 + 32'(i * 4), 1'b0, 1'b0);
            tick();
        end
        apply_stimulus(1'b1, 32'h1C, 1'b1, 1'b1);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check_output("flush_count", 32'(count), 32'd1);
        check_output("flush_head_pc", out_pc, 32'h14);
        check_output("flush_head_inst", out_inst, inst_of(32'h14));
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        check_output("flush_drained", 32'(count), 32'd0);

        // Flush on the last entry waits for the delay slot
        apply_stimulus(1'b1, 32'h20, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check_output("dsw_set", 32'(ds_wait), 32'd1);
        check_output("dsw_in_ready", 32'(in_ready), 32'd1);
        check_output("dsw_valid", 32'(out_valid), 32'd0);
        apply_stimulus(1'b1, 32'h24, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b1, 32'h80, 1'b0, 1'b0);
        #1;
        check_output("dsw_clear", 32'(ds_wait), 32'd0);
        check_output("dsw_head", out_pc, 32'h24);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check_output("dsw_target_count", 32'(count), 32'd2);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        check_output("dsw_target_head", out_pc, 32'h80);
        tick();

        // Full queue refuses a same-cycle push while popping
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 32'h30 + 32'(i * 4), 1'b0, 1'b0);
            tick();
        end
        apply_stimulus(1'b1, 32'h50, 1'b1, 1'b0);
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check_output("fullpop_count", 32'(count), 32'd3);
        check_output("fullpop_head", out_pc, 32'h34);

        // Asynchronous reset between edges
        #1;
        resetn = 1'b0;
        #1;
        check_output("async_count", 32'(count), 32'd0);
        check_output("async_valid", 32'(out_valid), 32'd0);
        resetn = 1'b1;
        tick();

        // Empty queue, fetch and consume in the same cycle
        apply_stimulus(1'b1, 32'h40, 1'b1, 1'b0);
        #1;
        if (BYP) begin
            check_output("byp_valid", 32'(out_valid), 32'd1);
            check_output("byp_pc", out_pc, 32'h40);
        end else begin
            check_output("nobyp_valid", 32'(out_valid), 32'd0);
        end
        tick();
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        if (BYP) begin
            check_output("byp_count", 32'(count), 32'd0);
            check_output("byp_after_valid", 32'(out_valid), 32'd0);
        end else begin
            check_output("nobyp_late_valid", 32'(out_valid), 32'd1);
            check_output("nobyp_late_pc", out_pc, 32'h40);
        end
        tick();

        // Mixed traffic with occasional flushes, checked by the model
        for (int i = 0; i < 80; i++) begin
            apply_stimulus(1'($urandom_range(0, 1)), 32'h100 + 32'(i * 4),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
            tick();
        end
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0);
        repeat (6) tick();
        check_output("final_count", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
